// File: rtl/reg_bus_datapath.sv
// reg_bus_datapath: shared one-hot bus joining NUM_REGS general registers, Y, Z, HI, LO
// and an external source. A combinational ALU (A=Y, B=bus) feeds Z. A serial
// shift-add multiplier / restoring divider writes HI/LO itself when it finishes.
// A sticky flag records any cycle in which more than one source drove the bus.
// Build option: define MD_SIGNED_EN for two's-complement multiply/divide.
// Without it, operands are unsigned.
//
// Handshake: md_start is sampled only in IDLE. Operands are latched on that edge
// (A=Y, B=bus). md_busy stays high through RUN and DONE. md_done pulses for the
// single DONE cycle, md_dz is valid with it, and HI/LO are written on the edge
// that ends DONE.
module reg_bus_datapath #(
  parameter int DATA_W   = 32,
  parameter int NUM_REGS = 16,
  parameter int R0_ZERO  = 1
) (
  input  logic                clock,
  input  logic                clear,
  input  logic [NUM_REGS-1:0] reg_in,
  input  logic [NUM_REGS-1:0] reg_out,
  input  logic                y_in,
  input  logic                z_in,
  input  logic                z_out,
  input  logic                hi_in,
  input  logic                lo_in,
  input  logic                hi_out,
  input  logic                lo_out,
  input  logic                ext_out,
  input  logic [DATA_W-1:0]   ext_data,
  input  logic [3:0]          alu_op,
  input  logic                md_start,
  input  logic                md_op,
  output logic [DATA_W-1:0]   bus,
  output logic                md_busy,
  output logic                md_done,
  output logic                md_dz,
  output logic                bus_err,
  output logic [1:0]          md_state
);

  localparam int SH_W = $clog2(DATA_W);
  localparam int NSRC = NUM_REGS + 4;
  localparam logic [SH_W-1:0] LAST_STEP = SH_W'(DATA_W - 1);

  typedef enum logic [1:0] {
    MD_IDLE = 2'd0,
    MD_RUN  = 2'd1,
    MD_DONE = 2'd2
  } md_state_t;

  logic [DATA_W-1:0] regs_q [NUM_REGS];
  logic [DATA_W-1:0] y_q, z_q, hi_q, lo_q;
  logic              bus_err_q;

  md_state_t         state_q, state_d;
  logic [SH_W-1:0]   cnt_q, cnt_d;
  logic              op_q, dz_q;
  logic [DATA_W-1:0] acc_hi_q, acc_lo_q, b_q, a_q;
`ifdef MD_SIGNED_EN
  logic              neg_res_q, neg_rem_q;
`endif

  logic [NSRC-1:0]   src_sel;
  logic              src_multi;
  logic [DATA_W-1:0] bus_or;
  logic [DATA_W-1:0] alu_res;
  logic [2*DATA_W-1:0] rot_tmp;
  logic [SH_W-1:0]   shamt;

  logic [DATA_W-1:0] a_mag, b_mag;
  logic [DATA_W:0]   mul_sum, div_sh;
  logic              div_ge;
  logic [DATA_W-1:0] div_rem;
  logic [DATA_W-1:0] hi_step, lo_step;
  logic [2*DATA_W-1:0] prod;
  logic [DATA_W-1:0] quot, rem;
  logic [DATA_W-1:0] res_hi, res_lo;
  logic              md_wr;

  // Bus contention is any source vector with more than one bit set.
  assign src_sel   = {ext_out, lo_out, hi_out, z_out, reg_out};
  assign src_multi = (src_sel & (src_sel - {{(NSRC-1){1'b0}}, 1'b1})) != '0;

  // Bus mux: OR of the selected sources, forced to zero on contention.
  always_comb begin
    bus_or = '0;
    for (int i = 0; i < NUM_REGS; i++) begin
      if (reg_out[i] && !(R0_ZERO != 0 && i == 0)) bus_or = bus_or | regs_q[i];
    end
    if (z_out)   bus_or = bus_or | z_q;
    if (hi_out)  bus_or = bus_or | hi_q;
    if (lo_out)  bus_or = bus_or | lo_q;
    if (ext_out) bus_or = bus_or | ext_data;
    bus = src_multi ? '0 : bus_or;
  end

  // ALU: A is Y, B is the bus; shift amounts use only the low bits of B.
  always_comb begin
    alu_res = '0;
    rot_tmp = '0;
    shamt   = bus[SH_W-1:0];
    case (alu_op)
      4'd0:  alu_res = y_q + bus;
      4'd1:  alu_res = y_q - bus;
      4'd2:  alu_res = y_q & bus;
      4'd3:  alu_res = y_q | bus;
      4'd4:  alu_res = y_q >> shamt;
      4'd5:  alu_res = DATA_W'($signed(y_q) >>> shamt);
      4'd6:  alu_res = y_q << shamt;
      4'd7: begin
        rot_tmp = {y_q, y_q} >> shamt;
        alu_res = rot_tmp[DATA_W-1:0];
      end
      4'd8: begin
        rot_tmp = {y_q, y_q} << shamt;
        alu_res = rot_tmp[2*DATA_W-1:DATA_W];
      end
      4'd9:  alu_res = -bus;
      4'd10: alu_res = ~bus;
      default: alu_res = '0;
    endcase
  end

  // Operand magnitudes taken at start; signs are reapplied when the result is formed.
  always_comb begin
`ifdef MD_SIGNED_EN
    a_mag = y_q[DATA_W-1] ? -y_q : y_q;
    b_mag = bus[DATA_W-1] ? -bus : bus;
`else
    a_mag = y_q;
    b_mag = bus;
`endif
  end

  // One multiply (shift-add) or divide (restoring) step on the accumulators.
  always_comb begin
    mul_sum = {1'b0, acc_hi_q} + (acc_lo_q[0] ? {1'b0, b_q} : '0);
    div_sh  = {acc_hi_q, acc_lo_q[DATA_W-1]};
    div_ge  = div_sh >= {1'b0, b_q};
    div_rem = div_sh[DATA_W-1:0] - b_q;
    if (op_q) begin
      hi_step = div_ge ? div_rem : div_sh[DATA_W-1:0];
      lo_step = {acc_lo_q[DATA_W-2:0], div_ge};
    end else begin
      hi_step = mul_sum[DATA_W:1];
      lo_step = {mul_sum[0], acc_lo_q[DATA_W-1:1]};
    end
  end

  // Final HI/LO values presented during DONE, including sign fix-up and divide-by-zero.
  always_comb begin
    prod = {acc_hi_q, acc_lo_q};
    quot = acc_lo_q;
    rem  = acc_hi_q;
`ifdef MD_SIGNED_EN
    if (neg_res_q) prod = -prod;
    if (neg_res_q) quot = -quot;
    if (neg_rem_q) rem  = -rem;
`endif
    if (!op_q) begin
      res_hi = prod[2*DATA_W-1:DATA_W];
      res_lo = prod[DATA_W-1:0];
    end else if (dz_q) begin
      res_hi = a_q;
      res_lo = '1;
    end else begin
      res_hi = rem;
      res_lo = quot;
    end
  end

  // Mul/div FSM next state and status outputs.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    md_busy = 1'b0;
    md_done = 1'b0;
    md_dz   = 1'b0;
    md_wr   = 1'b0;
    case (state_q)
      MD_IDLE: begin
        if (md_start) begin
          state_d = MD_RUN;
          cnt_d   = '0;
        end
      end
      MD_RUN: begin
        md_busy = 1'b1;
        cnt_d   = cnt_q + SH_W'(1);
        if (cnt_q == LAST_STEP) state_d = MD_DONE;
      end
      MD_DONE: begin
        md_busy = 1'b1;
        md_done = 1'b1;
        md_dz   = dz_q;
        md_wr   = 1'b1;
        state_d = MD_IDLE;
      end
      default: state_d = MD_IDLE;
    endcase
  end

  assign md_state = state_q;
  assign bus_err  = bus_err_q;

  // FSM state and step counter.
  always_ff @(posedge clock or posedge clear) begin
    if (clear) begin
      state_q <= MD_IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Mul/div operand latch and accumulator stepping.
  always_ff @(posedge clock or posedge clear) begin
    if (clear) begin
      op_q     <= 1'b0;
      dz_q     <= 1'b0;
      acc_hi_q <= '0;
      acc_lo_q <= '0;
      b_q      <= '0;
      a_q      <= '0;
`ifdef MD_SIGNED_EN
      neg_res_q <= 1'b0;
      neg_rem_q <= 1'b0;
`endif
    end else if (state_q == MD_IDLE && md_start) begin
      op_q     <= md_op;
      dz_q     <= (bus == '0);
      acc_hi_q <= '0;
      acc_lo_q <= a_mag;
      b_q      <= b_mag;
      a_q      <= y_q;
`ifdef MD_SIGNED_EN
      neg_res_q <= y_q[DATA_W-1] ^ bus[DATA_W-1];
      neg_rem_q <= y_q[DATA_W-1];
`endif
    end else if (state_q == MD_RUN) begin
      acc_hi_q <= hi_step;
      acc_lo_q <= lo_step;
    end
  end

  // General registers, Y, Z and the sticky contention flag.
  always_ff @(posedge clock or posedge clear) begin
    if (clear) begin
      for (int i = 0; i < NUM_REGS; i++) regs_q[i] <= '0;
      y_q       <= '0;
      z_q       <= '0;
      bus_err_q <= 1'b0;
    end else begin
      for (int i = 0; i < NUM_REGS; i++) begin
        if (reg_in[i] && !(R0_ZERO != 0 && i == 0)) regs_q[i] <= bus;
      end
      if (y_in) y_q <= bus;
      if (z_in) z_q <= alu_res;
      if (src_multi) bus_err_q <= 1'b1;
    end
  end

  // HI/LO: a completing mul/div takes priority over bus loads on the same edge.
  always_ff @(posedge clock or posedge clear) begin
    if (clear) begin
      hi_q <= '0;
      lo_q <= '0;
    end else if (md_wr) begin
      hi_q <= res_hi;
      lo_q <= res_lo;
    end else begin
      if (hi_in) hi_q <= bus;
      if (lo_in) lo_q <= bus;
    end
  end

endmodule

// File: tb/tb_reg_bus_datapath.sv
// Directed bench for reg_bus_datapath (DATA_W=32, NUM_REGS=16, R0_ZERO=1).
// Define MD_SIGNED_EN for both RTL and bench to cover the signed build.
module tb_reg_bus_datapath;
  localparam int W = 32;
  localparam int N = 16;

  logic         clock;
  logic         clear;
  logic [N-1:0] reg_in, reg_out;
  logic         y_in, z_in, z_out, hi_in, lo_in, hi_out, lo_out, ext_out;
  logic [W-1:0] ext_data;
  logic [3:0]   alu_op;
  logic         md_start, md_op;
  logic [W-1:0] bus;
  logic         md_busy, md_done, md_dz, bus_err;
  logic [1:0]   md_state;

  int n_cmp = 0;
  int n_err = 0;
  logic [W-1:0] exp_q[$];

  // ALU vectors: Y, B, op, expected Z
  localparam logic [W-1:0] ALU_Y [13] = '{32'h7, 32'h7, 32'h7, 32'h7, 32'h8000_0000, 32'h8000_0000,
                                          32'h1, 32'h1, 32'h1, 32'h7, 32'h7, 32'h7, 32'h5};
  localparam logic [W-1:0] ALU_B [13] = '{32'h5, 32'h5, 32'h5, 32'h5, 32'h4, 32'h4,
                                          32'd31, 32'h4, 32'h4, 32'h5, 32'h5, 32'h5, 32'h7};
  localparam logic [3:0]   ALU_OP[13] = '{4'd0, 4'd1, 4'd2, 4'd3, 4'd4, 4'd5,
                                          4'd6, 4'd7, 4'd8, 4'd9, 4'd10, 4'd12, 4'd1};
  localparam logic [W-1:0] ALU_E [13] = '{32'hC, 32'h2, 32'h5, 32'h7, 32'h0800_0000, 32'hF800_0000,
                                          32'h8000_0000, 32'h1000_0000, 32'h10, 32'hFFFF_FFFB,
                                          32'hFFFF_FFFA, 32'h0, 32'hFFFF_FFFE};

  // Multiply vectors: A, B, expected HI, expected LO
  localparam logic [W-1:0] MUL_A [3] = '{32'h0001_0000, 32'hFFFF_FFFE, 32'hFFFF_FFFF};
  localparam logic [W-1:0] MUL_B [3] = '{32'h0003_0000, 32'h3, 32'hFFFF_FFFF};
`ifdef MD_SIGNED_EN
  localparam logic [W-1:0] MUL_H [3] = '{32'h3, 32'hFFFF_FFFF, 32'h0};
  localparam logic [W-1:0] MUL_L [3] = '{32'h0, 32'hFFFF_FFFA, 32'h1};
`else
  localparam logic [W-1:0] MUL_H [3] = '{32'h3, 32'h2, 32'hFFFF_FFFE};
  localparam logic [W-1:0] MUL_L [3] = '{32'h0, 32'hFFFF_FFFA, 32'h1};
`endif

  // Divide vectors: A, B, expected HI (remainder), expected LO (quotient), expected dz
  localparam logic [W-1:0] DIV_A [3] = '{32'd100, 32'd100, 32'hFFFF_FFF9};
  localparam logic [W-1:0] DIV_B [3] = '{32'd7, 32'd0, 32'd2};
`ifdef MD_SIGNED_EN
  localparam logic [W-1:0] DIV_H [3] = '{32'd2, 32'd100, 32'hFFFF_FFFF};
  localparam logic [W-1:0] DIV_L [3] = '{32'd14, 32'hFFFF_FFFF, 32'hFFFF_FFFD};
`else
  localparam logic [W-1:0] DIV_H [3] = '{32'd2, 32'd100, 32'd1};
  localparam logic [W-1:0] DIV_L [3] = '{32'd14, 32'hFFFF_FFFF, 32'h7FFF_FFFC};
`endif
  localparam logic DIV_Z [3] = '{1'b0, 1'b1, 1'b0};

  reg_bus_datapath #(.DATA_W(W), .NUM_REGS(N), .R0_ZERO(1)) dut (
    .clock(clock), .clear(clear), .reg_in(reg_in), .reg_out(reg_out),
    .y_in(y_in), .z_in(z_in), .z_out(z_out), .hi_in(hi_in), .lo_in(lo_in),
    .hi_out(hi_out), .lo_out(lo_out), .ext_out(ext_out), .ext_data(ext_data),
    .alu_op(alu_op), .md_start(md_start), .md_op(md_op), .bus(bus),
    .md_busy(md_busy), .md_done(md_done), .md_dz(md_dz), .bus_err(bus_err),
    .md_state(md_state)
  );

  // Clock
  initial clock = 1'b0;
  always #5 clock = ~clock;

  // ---------------- driver tasks ----------------
  task automatic clear_ctl();
    reg_in = '0; reg_out = '0; y_in = 0; z_in = 0; z_out = 0;
    hi_in = 0; lo_in = 0; hi_out = 0; lo_out = 0; ext_out = 0;
    ext_data = '0; alu_op = '0; md_start = 0; md_op = 0;
  endtask

  task automatic cycle();
    @(posedge clock);
    #1;
  endtask

  task automatic load_y(input logic [W-1:0] v);
    ext_data = v; ext_out = 1; y_in = 1;
    cycle();
    clear_ctl();
  endtask

  task automatic load_reg(input int idx, input logic [W-1:0] v);
    ext_data = v; ext_out = 1; reg_in[idx] = 1'b1;
    cycle();
    clear_ctl();
  endtask

  task automatic read_reg(input int idx, output logic [W-1:0] v);
    reg_out = '0; reg_out[idx] = 1'b1;
    #1 v = bus;
    reg_out = '0;
  endtask

  task automatic read_hilo(output logic [W-1:0] h, output logic [W-1:0] l);
    hi_out = 1; #1 h = bus; hi_out = 0;
    lo_out = 1; #1 l = bus; lo_out = 0;
  endtask

  // Starts an op and waits for md_done; lat counts edges including the start edge.
  task automatic start_and_wait(input logic [W-1:0] a, input logic [W-1:0] b, input logic op,
                                output int lat, output logic dz);
    load_y(a);
    ext_data = b; ext_out = 1; md_start = 1; md_op = op;
    cycle();
    clear_ctl();
    lat = 1;
    while (!md_done && lat < 45) begin
      cycle();
      lat++;
    end
    dz = md_dz;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    logic [W-1:0] v, h, l;
    n_cmp++; if (bus !== 32'h0) begin n_err++; $display("FAIL reset_bus: got %h expected 0", bus); end
    n_cmp++; if ({md_busy, md_done, md_dz, bus_err} !== 4'b0) begin
      n_err++; $display("FAIL reset_flags: got %b expected 0000", {md_busy, md_done, md_dz, bus_err});
    end
    read_reg(3, v);
    n_cmp++; if (v !== 32'h0) begin n_err++; $display("FAIL reset_r3: got %h expected 0", v); end
    read_hilo(h, l);
    n_cmp++; if ({h, l} !== 64'h0) begin n_err++; $display("FAIL reset_hilo: got %h %h expected 0 0", h, l); end
  endtask

  task automatic test_bus_regs();
    logic [W-1:0] v;
    load_reg(3, 32'h1234_5678);
    read_reg(3, v);
    n_cmp++; if (v !== 32'h1234_5678) begin n_err++; $display("FAIL r3_load: got %h expected 12345678", v); end
    load_reg(0, 32'h5);
    read_reg(0, v);
    n_cmp++; if (v !== 32'h0) begin n_err++; $display("FAIL r0_zero: got %h expected 0", v); end
    // Two write enables in one cycle capture the same bus value.
    ext_data = 32'hA5A5_0001; ext_out = 1; reg_in[5] = 1; reg_in[9] = 1;
    cycle(); clear_ctl();
    read_reg(5, v);
    n_cmp++; if (v !== 32'hA5A5_0001) begin n_err++; $display("FAIL multi_wr_r5: got %h expected a5a50001", v); end
    read_reg(9, v);
    n_cmp++; if (v !== 32'hA5A5_0001) begin n_err++; $display("FAIL multi_wr_r9: got %h expected a5a50001", v); end
    #1;
    n_cmp++; if (bus !== 32'h0) begin n_err++; $display("FAIL bus_idle: got %h expected 0", bus); end
  endtask

  task automatic test_alu();
    for (int i = 0; i < 13; i++) begin
      load_y(ALU_Y[i]);
      ext_data = ALU_B[i]; ext_out = 1; alu_op = ALU_OP[i]; z_in = 1;
      cycle(); clear_ctl();
      z_out = 1;
      #1;
      n_cmp++;
      if (bus !== ALU_E[i]) begin
        n_err++; $display("FAIL alu_%0d op%0d: got %h expected %h", i, ALU_OP[i], bus, ALU_E[i]);
      end
      z_out = 0;
    end
  endtask

  task automatic test_mul();
    int lat;
    logic dz;
    logic [W-1:0] h, l, eh, el;
    for (int i = 0; i < 3; i++) begin
      exp_q.push_back(MUL_H[i]);
      exp_q.push_back(MUL_L[i]);
    end
    for (int i = 0; i < 3; i++) begin
      start_and_wait(MUL_A[i], MUL_B[i], 1'b0, lat, dz);
      n_cmp++; if (lat != 33) begin n_err++; $display("FAIL mul_lat_%0d: got %0d expected 33", i, lat); end
      n_cmp++; if (md_busy !== 1'b1) begin n_err++; $display("FAIL mul_busy_done_%0d: got %b expected 1", i, md_busy); end
      cycle();
      n_cmp++; if ({md_busy, md_done} !== 2'b00) begin
        n_err++; $display("FAIL mul_idle_%0d: got %b expected 00", i, {md_busy, md_done});
      end
      read_hilo(h, l);
      eh = exp_q.pop_front();
      el = exp_q.pop_front();
      n_cmp++; if (h !== eh) begin n_err++; $display("FAIL mul_hi_%0d: got %h expected %h", i, h, eh); end
      n_cmp++; if (l !== el) begin n_err++; $display("FAIL mul_lo_%0d: got %h expected %h", i, l, el); end
    end
  endtask

  task automatic test_div();
    int lat;
    logic dz;
    logic [W-1:0] h, l;
    for (int i = 0; i < 3; i++) begin
      start_and_wait(DIV_A[i], DIV_B[i], 1'b1, lat, dz);
      n_cmp++; if (lat != 33) begin n_err++; $display("FAIL div_lat_%0d: got %0d expected 33", i, lat); end
      n_cmp++; if (dz !== DIV_Z[i]) begin n_err++; $display("FAIL div_dz_%0d: got %b expected %b", i, dz, DIV_Z[i]); end
      cycle();
      read_hilo(h, l);
      n_cmp++; if (h !== DIV_H[i]) begin n_err++; $display("FAIL div_hi_%0d: got %h expected %h", i, h, DIV_H[i]); end
      n_cmp++; if (l !== DIV_L[i]) begin n_err++; $display("FAIL div_lo_%0d: got %h expected %h", i, l, DIV_L[i]); end
    end
  endtask

  task automatic test_back_to_back();
    int lat;
    logic [W-1:0] h, l;
    // Divide 100/7, then try to restart as a multiply 5 edges in with a new Y.
    load_y(32'd100);
    ext_data = 32'd7; ext_out = 1; md_start = 1; md_op = 1;
    cycle(); clear_ctl();
    lat = 1;
    repeat (5) begin cycle(); lat++; end
    ext_data = 32'd3; ext_out = 1; y_in = 1; md_start = 1; md_op = 0;
    cycle(); clear_ctl(); lat++;
    while (!md_done && lat < 45) begin cycle(); lat++; end
    n_cmp++; if (lat != 33) begin n_err++; $display("FAIL restart_lat: got %0d expected 33", lat); end
    cycle();
    read_hilo(h, l);
    n_cmp++; if ({h, l} !== {32'd2, 32'd14}) begin
      n_err++; $display("FAIL restart_result: got %h %h expected 2 e", h, l);
    end
  endtask

  task automatic test_contention();
    int lat;
    logic dz;
    logic [W-1:0] h, l;
    // lo_in alone loads LO.
    ext_data = 32'hDEAD_BEEF; ext_out = 1; lo_in = 1;
    cycle(); clear_ctl();
    read_hilo(h, l);
    n_cmp++; if (l !== 32'hDEAD_BEEF) begin n_err++; $display("FAIL lo_in_load: got %h expected deadbeef", l); end
    // Bus loads on the completion edge lose to the FSM write.
    start_and_wait(32'h0001_0000, 32'h0003_0000, 1'b0, lat, dz);
    ext_data = 32'h1111_2222; ext_out = 1; lo_in = 1; hi_in = 1;
    cycle(); clear_ctl();
    read_hilo(h, l);
    n_cmp++; if ({h, l} !== {32'h3, 32'h0}) begin
      n_err++; $display("FAIL fsm_over_bus: got %h %h expected 3 0", h, l);
    end
    lo_in = 1; ext_data = 32'hDEAD_BEEF; ext_out = 1;
    cycle(); clear_ctl();
    // Two drivers: bus reads 0 and the flag sets on the next edge.
    load_reg(1, 32'hAAAA);
    n_cmp++; if (bus_err !== 1'b0) begin n_err++; $display("FAIL err_pre: got %b expected 0", bus_err); end
    reg_out[1] = 1; z_out = 1;
    #1;
    n_cmp++; if (bus !== 32'h0) begin n_err++; $display("FAIL contention_bus: got %h expected 0", bus); end
    cycle(); clear_ctl();
    n_cmp++; if (bus_err !== 1'b1) begin n_err++; $display("FAIL err_set: got %b expected 1", bus_err); end
    repeat (3) cycle();
    n_cmp++; if (bus_err !== 1'b1) begin n_err++; $display("FAIL err_sticky: got %b expected 1", bus_err); end
  endtask

  task automatic test_reset_mid_op();
    int seen;
    logic [W-1:0] h, l, v;
    load_y(32'h0001_0000);
    ext_data = 32'h0003_0000; ext_out = 1; md_start = 1; md_op = 0;
    cycle(); clear_ctl();
    repeat (10) cycle();
    #2 clear = 1;
    #1;
    n_cmp++; if (md_busy !== 1'b0) begin n_err++; $display("FAIL abort_busy: got %b expected 0", md_busy); end
    n_cmp++; if (bus_err !== 1'b0) begin n_err++; $display("FAIL abort_err: got %b expected 0", bus_err); end
    @(posedge clock);
    #1 clear = 0;
    read_hilo(h, l);
    n_cmp++; if ({h, l} !== 64'h0) begin n_err++; $display("FAIL abort_hilo: got %h %h expected 0 0", h, l); end
    read_reg(1, v);
    n_cmp++; if (v !== 32'h0) begin n_err++; $display("FAIL abort_r1: got %h expected 0", v); end
    seen = 0;
    repeat (40) begin
      cycle();
      if (md_done || md_busy) seen++;
    end
    n_cmp++; if (seen != 0) begin n_err++; $display("FAIL abort_no_done: got %0d active cycles expected 0", seen); end
  endtask

  initial begin
    clear_ctl();
    clear = 1;
    repeat (2) @(posedge clock);
    #1;
    test_reset();
    clear = 0;
    cycle();
    test_bus_regs();
    test_alu();
    test_mul();
    test_div();
    test_back_to_back();
    test_contention();
    test_reset_mid_op();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
